// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU operation codes, LEGv8 opcode match values
// and the packed issue-entry layout used between the decoder and the ALU.
package alu_pkg;

  localparam int unsigned ALU_N = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_EOR   = 4'b1100;

  // R-type and D-type rows match all of instr[31:21]
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // I-type rows match instr[31:22], CB-type matches instr[31:24]
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  typedef struct packed {
    logic [3:0]       operation;
    logic [ALU_N-1:0] in1;
    logic [ALU_N-1:0] in2;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// DEPTH-entry synchronous FIFO for decoded ALU issue entries.
// Head data reads as zero while empty; storage itself is never reset.
module alu_issue_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 132
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// LEGv8 -> ALU issue decoder with a buffered valid/ready output.
// Build option: ILLEGAL_TRAP_EN drops unknown opcodes and raises a sticky illegal flag.
module alu_issue_decoder
  import alu_pkg::*;
#(
  parameter int unsigned n     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instr,
  input  logic [n-1:0] rd1,
  input  logic [n-1:0] rd2,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [3:0]   operation,
  output logic [n-1:0] in1,
  output logic [n-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         illegal
);

  localparam int unsigned EW = 4 + 2*n;

  logic         legal;
  logic [3:0]   dec_op;
  logic [n-1:0] dec_in1;
  logic [n-1:0] dec_in2;
  logic [n-1:0] imm12;
  logic [n-1:0] imm9;
  logic         fifo_push;
  logic         fifo_full;
  logic         fifo_empty;
  logic [EW-1:0] head;
  logic [$clog2(DEPTH+1)-1:0] unused_count;
  logic         unused_bits;

  assign imm12 = {{(n-12){1'b0}}, instr[21:10]};
  assign imm9  = {{(n-9){instr[20]}}, instr[20:12]};
  assign unused_bits = ^instr[9:0];

  always_comb begin
    legal   = 1'b1;
    dec_op  = ALU_ADD;
    dec_in1 = rd1;
    dec_in2 = rd2;
    if (instr[31:21] == OPC_ADD) begin
      dec_op = ALU_ADD;
    end else if (instr[31:21] == OPC_SUB) begin
      dec_op = ALU_SUB;
    end else if (instr[31:21] == OPC_AND) begin
      dec_op = ALU_AND;
    end else if (instr[31:21] == OPC_ORR) begin
      dec_op = ALU_ORR;
    end else if (instr[31:21] == OPC_EOR) begin
      dec_op = ALU_EOR;
    end else if (instr[31:22] == OPC_ADDI) begin
      dec_in2 = imm12;
    end else if (instr[31:22] == OPC_SUBI) begin
      dec_op  = ALU_SUB;
      dec_in2 = imm12;
    end else if (instr[31:21] == OPC_LDUR || instr[31:21] == OPC_STUR) begin
      dec_in2 = imm9;
    end else if (instr[31:24] == OPC_CBZ) begin
      // pass Rt through; the branch tests the ALU zero flag downstream
      dec_op  = ALU_PASSB;
      dec_in1 = '0;
    end else begin
      legal   = 1'b0;
      dec_in1 = '0;
      dec_in2 = '0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)                                  illegal_q <= 1'b0;
    else if (in_valid && in_ready && !legal)  illegal_q <= 1'b1;
  end

  assign illegal   = illegal_q;
  assign fifo_push = in_valid & in_ready & legal;
`else
  logic unused_legal;

  assign unused_legal = legal;
  assign illegal      = 1'b0;
  assign fifo_push    = in_valid & in_ready;
`endif

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (out_ready),
    .din   ({dec_op, dec_in1, dec_in2}),
    .dout  (head),
    .count (unused_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign {operation, in1, in2} = head;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder; expectations are hand-derived per instruction.
// Covers both builds: define ILLEGAL_TRAP_EN to exercise the trap variant.
module tb_alu_issue_decoder;
  import alu_pkg::*;

  localparam int N = 64;

  typedef struct {
    logic [31:0]  i;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic [N-1:0] e1;
    logic [N-1:0] e2;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  instr;
  logic [N-1:0] rd1, rd2;
  logic         in_valid, in_ready;
  logic [3:0]   operation;
  logic [N-1:0] in1, in2;
  logic         out_valid, out_ready, illegal;

  int checks = 0;
  int errors = 0;
  issue_entry_t sb[$];

  always #5 clk = ~clk;

  alu_issue_decoder #(.n(N), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .rd1       (rd1),
    .rd2       (rd2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .illegal   (illegal)
  );

  // drive one source beat; record the expected entry if it will be accepted on the coming edge
  task automatic send(input vec_t v, input logic ordy);
    in_valid  = 1'b1;
    instr     = v.i;
    rd1       = v.a;
    rd2       = v.b;
    out_ready = ordy;
    if (in_ready) sb.push_back({v.op, v.e1, v.e2});
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; instr = '0; rd1 = '0; rd2 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (operation !== 4'h0) begin errors++; $display("FAIL reset_operation: got %h exp 0", operation); end
    checks++; if (in1 !== '0 || in2 !== '0) begin errors++; $display("FAIL reset_operands: got %h %h exp 0 0", in1, in2); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b exp 0", illegal); end
  endtask

  task automatic test_alu_ops();
    vec_t v[5];
    issue_entry_t e;
    v[0] = '{32'h8B020020, 64'd5,  64'd7, 4'b0010, 64'd5,  64'd7};
    v[1] = '{32'hCB020020, 64'd20, 64'd6, 4'b0110, 64'd20, 64'd6};
    v[2] = '{32'h8A020020, 64'hF0, 64'h3C, 4'b0000, 64'hF0, 64'h3C};
    v[3] = '{32'hAA020020, 64'h11, 64'h22, 4'b0001, 64'h11, 64'h22};
    v[4] = '{32'hCA020020, 64'hAA, 64'h55, 4'b1100, 64'hAA, 64'h55};
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || {operation, in1, in2} !== e) begin
          errors++;
          $display("FAIL alu_op[%0d]: got v=%b op=%h in1=%h in2=%h exp op=%h in1=%h in2=%h",
                   k-1, out_valid, operation, in1, in2, e.operation, e.in1, e.in2);
        end
      end
      if (k < 5) send(v[k], 1'b1); else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_ops_drained: got %b exp 0", out_valid); end
  endtask

  task automatic test_imm();
    vec_t v[2];
    issue_entry_t e;
    v[0] = '{32'h91001021, 64'd10, 64'd99, 4'b0010, 64'd10, 64'd4};
    v[1] = '{32'hD13FFC21, 64'd3,  64'd99, 4'b0110, 64'd3,  64'hFFF};
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || {operation, in1, in2} !== e) begin
          errors++;
          $display("FAIL imm[%0d]: got v=%b op=%h in1=%h in2=%h exp op=%h in1=%h in2=%h",
                   k-1, out_valid, operation, in1, in2, e.operation, e.in1, e.in2);
        end
      end
      if (k < 2) send(v[k], 1'b1); else in_valid = 1'b0;
    end
  endtask

  task automatic test_mem_cbz();
    vec_t v[3];
    issue_entry_t e;
    v[0] = '{32'hF85F8000, 64'h100, 64'd1, 4'b0010, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8};
    v[1] = '{32'hF8010043, 64'h200, 64'd9, 4'b0010, 64'h200, 64'd16};
    v[2] = '{32'hB4000040, 64'h55,  64'd0, 4'b0111, 64'd0,   64'd0};
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || {operation, in1, in2} !== e) begin
          errors++;
          $display("FAIL mem_cbz[%0d]: got v=%b op=%h in1=%h in2=%h exp op=%h in1=%h in2=%h",
                   k-1, out_valid, operation, in1, in2, e.operation, e.in1, e.in2);
        end
      end
      if (k < 3) send(v[k], 1'b1); else in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    vec_t add_v = '{32'h8B020020, 64'd1, 64'd2, 4'b0010, 64'd1, 64'd2};
    vec_t sub_v = '{32'hCB020020, 64'd3, 64'd4, 4'b0110, 64'd3, 64'd4};
    vec_t and_v = '{32'h8A020020, 64'd5, 64'd6, 4'b0000, 64'd5, 64'd6};
    issue_entry_t e;
    @(negedge clk); send(add_v, 1'b0);
    @(negedge clk); send(sub_v, 1'b0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready got %b exp 0", in_ready); end
    send(and_v, 1'b0);
    @(negedge clk);
    checks++; if (sb.size() != 2) begin errors++; $display("FAIL bp_accepted: got %0d exp 2", sb.size()); end
    e = (sb.size() > 0) ? sb[0] : '0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || {operation, in1, in2} !== e) begin
      errors++;
      $display("FAIL bp_stall_head: got v=%b rdy=%b op=%h in1=%h in2=%h exp op=%h",
               out_valid, in_ready, operation, in1, in2, e.operation);
    end
    out_ready = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || {operation, in1, in2} !== e) begin
      errors++;
      $display("FAIL bp_drain_sub: got v=%b rdy=%b op=%h exp op=%h", out_valid, in_ready, operation, e.operation);
    end
    send(and_v, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || {operation, in1, in2} !== e) begin
      errors++;
      $display("FAIL bp_push_pop_and: got v=%b rdy=%b op=%h in1=%h exp op=%h in1=%h",
               out_valid, in_ready, operation, in1, e.operation, e.in1);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    issue_entry_t e;
    @(negedge clk);
    in_valid = 1'b1; instr = 32'h0; rd1 = 64'h99; rd2 = 64'h77; out_ready = 1'b1;
`ifndef ILLEGAL_TRAP_EN
    if (in_ready) sb.push_back({4'b0010, 64'd0, 64'd0});
`endif
    @(negedge clk);
    in_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_dropped: out_valid got %b exp 0", out_valid); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b exp 1", illegal); end
    repeat (10) @(negedge clk);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b exp 1", illegal); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_cleared: got %b exp 0", illegal); end
`else
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (out_valid !== 1'b1 || {operation, in1, in2} !== e) begin
      errors++;
      $display("FAIL illegal_bubble: got v=%b op=%h in1=%h in2=%h exp op=%h in1=%h in2=%h",
               out_valid, operation, in1, in2, e.operation, e.in1, e.in2);
    end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_tied: got %b exp 0", illegal); end
    repeat (10) @(negedge clk);
    checks++; if (illegal !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal_idle: got ill=%b v=%b exp 0 0", illegal, out_valid); end
`endif
  endtask

  task automatic test_reset_mid();
    vec_t add_v  = '{32'h8B020020, 64'd1,  64'd2,  4'b0010, 64'd1,  64'd2};
    vec_t sub_v  = '{32'hCB020020, 64'd3,  64'd4,  4'b0110, 64'd3,  64'd4};
    vec_t add2_v = '{32'h8B020020, 64'd11, 64'd22, 4'b0010, 64'd11, 64'd22};
    issue_entry_t e;
    @(negedge clk); send(add_v, 1'b0);
    @(negedge clk); send(sub_v, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || operation !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_flush: got v=%b rdy=%b op=%h exp 0 1 0", out_valid, in_ready, operation);
    end
    send(add2_v, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (out_valid !== 1'b1 || {operation, in1, in2} !== e) begin
      errors++;
      $display("FAIL rstmid_add: got v=%b op=%h in1=%h in2=%h exp op=%h in1=%h in2=%h",
               out_valid, operation, in1, in2, e.operation, e.in1, e.in2);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_alone: got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_imm();
    test_mem_cbz();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
